fetch_unit: RTL

Instruction fetch stage of the 16-bit CPU, directly upstream of the opcode decoder. Maintains the program counter and issues word reads to instruction memory over a request/grant + response-valid handshake. Buffers up to two returned instructions and presents them to decode with a valid/ready handshake; `opcode` (instr[15:13]) drives the control decoder. Accepts a redirect (jump/taken branch) from downstream, flushing buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response,
// redirect from downstream, and the instruction handshake to decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [2:0]  opcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, two-deep fetch buffer, in-order response
// tracking and redirect flush with discard of stale in-flight responses.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    logic [15:0] r_pc;
    logic [15:0] r_fifo_instr [2];
    logic [15:0] r_fifo_addr  [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_cnt;
    logic [1:0]  r_inflight;
    logic [1:0]  r_drop;
    logic [15:0] r_aq [2];
    logic        r_aq_rd;
    logic        r_aq_wr;

    logic        w_pop;
    logic [2:0]  w_used;
    logic        w_room;
    logic        w_req;
    logic        w_gnt;
    logic        w_rsp_drop;
    logic        w_rsp_keep;
    logic [15:0] w_head;

    assign w_pop  = bus.instr_valid & bus.instr_ready;
    assign w_used = {1'b0, r_inflight} + {1'b0, r_drop} + {1'b0, r_cnt};
    // A pop this cycle frees its slot for a new request immediately.
    assign w_room = (w_used - {2'b00, w_pop}) < 3'd2;
    assign w_req  = !reset & !bus.redirect & w_room;
    assign w_gnt  = w_req & bus.imem_gnt;

    assign w_rsp_drop = bus.imem_rvalid & (r_drop != 2'd0);
    assign w_rsp_keep = bus.imem_rvalid & (r_drop == 2'd0)
                      & (r_inflight != 2'd0);

    assign w_head = r_fifo_instr[r_rd_ptr];

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = !reset & (r_cnt != 2'd0);
    assign bus.instr       = w_head;
    assign bus.instr_pc    = r_fifo_addr[r_rd_ptr];
    assign bus.opcode      = w_head[15:13];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 2'd0;
            r_drop     <= 2'd0;
            r_aq_rd    <= 1'b0;
            r_aq_wr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= 16'h0000;
                r_fifo_addr[i]  <= 16'h0000;
                r_aq[i]         <= 16'h0000;
            end
        end else if (bus.redirect) begin
            // Everything still owed by memory becomes a discard credit.
            r_pc       <= bus.redirect_pc;
            r_rd_ptr   <= r_wr_ptr;
            r_cnt      <= 2'd0;
            r_drop     <= r_drop + r_inflight
                        - {1'b0, w_rsp_drop | w_rsp_keep};
            r_inflight <= 2'd0;
            r_aq_rd    <= 1'b0;
            r_aq_wr    <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_pc          <= r_pc + 16'd1;
                r_aq[r_aq_wr] <= r_pc;
                r_aq_wr       <= ~r_aq_wr;
            end
            if (w_rsp_keep) begin
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                r_fifo_addr[r_wr_ptr]  <= r_aq[r_aq_rd];
                r_wr_ptr               <= ~r_wr_ptr;
                r_aq_rd                <= ~r_aq_rd;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt      <= r_cnt + {1'b0, w_rsp_keep} - {1'b0, w_pop};
            r_inflight <= r_inflight + {1'b0, w_gnt}
                        - {1'b0, w_rsp_keep};
            r_drop     <= r_drop - {1'b0, w_rsp_drop};
        end
    end

endmodule
